stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 155 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch controller with run/pause/lap/clear buttons.
// A prescaler divides clk into count ticks; digits shows live count or a lap snapshot.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        lap_held,
    output logic        overflow
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} state_e;

    state_e        state_q, state_d;
    logic          ss_prev_q, lap_prev_q, clr_prev_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   cnt_q, cnt_d, cnt_inc;
    logic [15:0]   snap_q, snap_d;
    logic [15:0]   digits_q, digits_d;
    logic          ovf_q, ovf_d;
    logic          running_q, running_d;
    logic          lap_held_q, lap_held_d;
    logic          ev_clr, ev_ss, ev_lap;
    logic          counting, tick;
    logic [3:0]    nines, carry;

    // Lower-priority events are masked by any higher-priority event in the same cycle.
    assign ev_clr   = clear & ~clr_prev_q;
    assign ev_ss    = start_stop & ~ss_prev_q & ~ev_clr;
    assign ev_lap   = lap & ~lap_prev_q & ~ev_clr & ~ev_ss;

    assign counting = (state_q == StRun) || (state_q == StLap);
    assign tick     = counting && (pre_q == PW'(TICK_DIV - 1));

    assign nines[0] = (cnt_q[3:0]   == 4'd9);
    assign nines[1] = (cnt_q[7:4]   == 4'd9);
    assign nines[2] = (cnt_q[11:8]  == 4'd9);
    assign nines[3] = (cnt_q[15:12] == 4'd9);

    // carry[n]: digit n advances this cycle.
    assign carry = {tick & nines[0] & nines[1] & nines[2],
                    tick & nines[0] & nines[1],
                    tick & nines[0],
                    tick};

    always_comb begin
        cnt_inc = cnt_q;
        for (int n = 0; n < 4; n++) begin
            if (carry[n]) begin
                cnt_inc[4*n +: 4] = nines[n] ? 4'd0 : cnt_q[4*n +: 4] + 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        ovf_d   = ovf_q;

        if (counting) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            cnt_d = cnt_inc;
            if (tick && (&nines)) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (ev_ss) begin
                    state_d = StRun;
                end else if (ev_clr) begin
                    pre_d  = '0;
                    cnt_d  = '0;
                    snap_d = '0;
                    ovf_d  = 1'b0;
                end
            end
            StRun: begin
                if (ev_ss) begin
                    state_d = StPause;
                end else if (ev_lap) begin
                    state_d = StLap;
                    snap_d  = cnt_q;  // pre-increment value even if tick coincides
                end
            end
            StLap: begin
                if (ev_ss) begin
                    state_d = StPause;
                end else if (ev_lap) begin
                    state_d = StRun;
                end
            end
            StPause: begin
                if (ev_ss) begin
                    state_d = StRun;
                end else if (ev_clr) begin
                    state_d = StIdle;
                    pre_d   = '0;
                    cnt_d   = '0;
                    snap_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        running_d  = (state_d == StRun) || (state_d == StLap);
        lap_held_d = (state_d == StLap);
        digits_d   = lap_held_d ? snap_d : cnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ss_prev_q  <= start_stop;
            lap_prev_q <= lap;
            clr_prev_q <= clear;
            pre_q      <= '0;
            cnt_q      <= '0;
            snap_q     <= '0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
            running_q  <= 1'b0;
            lap_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ss_prev_q  <= start_stop;
            lap_prev_q <= lap;
            clr_prev_q <= clear;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
            running_q  <= running_d;
            lap_held_q <= lap_held_d;
        end
    end

    assign digits   = digits_q;
    assign running  = running_q;
    assign lap_held = lap_held_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic,
// every cycle compared against an integer-count reference model.
module tb_stopwatch_ctrl;

    localparam int unsigned TICK_DIV = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [15:0] digits;
    logic        running;
    logic        lap_held;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: decimal count as a plain integer.
    int m_mode;
    int m_cnt;
    int m_snap;
    int m_pre;
    bit m_ovf;
    bit p_ss, p_lp, p_cl;

    stopwatch_ctrl #(
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .digits    (digits),
        .running   (running),
        .lap_held  (lap_held),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit l, input bit c);
        bit e_cl, e_ss, e_lp, tk;
        int old_cnt;
        if (r) begin
            m_mode = M_IDLE;
            m_cnt  = 0;
            m_snap = 0;
            m_pre  = 0;
            m_ovf  = 0;
            p_ss   = s;
            p_lp   = l;
            p_cl   = c;
            return;
        end
        e_cl = c && !p_cl;
        e_ss = s && !p_ss && !e_cl;
        e_lp = l && !p_lp && !e_cl && !e_ss;
        p_ss = s;
        p_lp = l;
        p_cl = c;
        old_cnt = m_cnt;
        tk = 0;
        if (m_mode == M_RUN || m_mode == M_LAP) begin
            tk    = (m_pre == TICK_DIV - 1);
            m_pre = (m_pre + 1) % TICK_DIV;
        end
        if (tk) begin
            if (m_cnt == 9999) m_ovf = 1;
            m_cnt = (m_cnt + 1) % 10000;
        end
        case (m_mode)
            M_IDLE: begin
                if (e_ss) m_mode = M_RUN;
                else if (e_cl) begin
                    m_cnt = 0; m_snap = 0; m_pre = 0; m_ovf = 0;
                end
            end
            M_RUN: begin
                if (e_ss) m_mode = M_PAUSE;
                else if (e_lp) begin
                    m_mode = M_LAP;
                    m_snap = old_cnt;
                end
            end
            M_LAP: begin
                if (e_ss) m_mode = M_PAUSE;
                else if (e_lp) m_mode = M_RUN;
            end
            default: begin
                if (e_ss) m_mode = M_RUN;
                else if (e_cl) begin
                    m_mode = M_IDLE;
                    m_cnt = 0; m_snap = 0; m_pre = 0; m_ovf = 0;
                end
            end
        endcase
    endtask

    task automatic cycle(input bit r, input bit s, input bit l, input bit c);
        @(negedge clk);
        reset      = r;
        start_stop = s;
        lap        = l;
        clear      = c;
        @(posedge clk);
        model_step(r, s, l, c);
        #1;
        chk("model_digits", digits, bcd(m_mode == M_LAP ? m_snap : m_cnt));
        chk("model_running", 16'(running), 16'(m_mode == M_RUN || m_mode == M_LAP));
        chk("model_lap_held", 16'(lap_held), 16'(m_mode == M_LAP));
        chk("model_overflow", 16'(overflow), 16'(m_ovf));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    initial begin
        bit rs, ss, lp, cl;
        reset      = 1'b1;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;

        // Reset state
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("reset_digits", digits, 16'h0000);
        chk("reset_running", 16'(running), 16'h0000);

        // Run 10 ticks
        cycle(0, 1, 0, 0);
        idle_cycles(40);
        chk("run10_digits", digits, 16'h0010);
        chk("run10_running", 16'(running), 16'h0001);

        // Decimal carry and 9999 wrap
        idle_cycles(356);
        chk("pre_0099", digits, 16'h0099);
        idle_cycles(4);
        chk("carry_0100", digits, 16'h0100);
        idle_cycles(39596);
        chk("pre_9999", digits, 16'h9999);
        chk("pre_wrap_ovf", 16'(overflow), 16'h0000);
        idle_cycles(4);
        chk("wrap_0000", digits, 16'h0000);
        chk("wrap_ovf", 16'(overflow), 16'h0001);
        idle_cycles(8);
        chk("ovf_sticky", 16'(overflow), 16'h0001);

        // Lap freeze and release
        cycle(1, 0, 0, 0);
        chk("reset_ovf", 16'(overflow), 16'h0000);
        cycle(0, 1, 0, 0);
        idle_cycles(20);
        chk("lap_pre_0005", digits, 16'h0005);
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 31; i++) begin
            cycle(0, 0, 0, 0);
            chk("lap_frozen", digits, 16'h0005);
            chk("lap_held_hi", 16'(lap_held), 16'h0001);
        end
        cycle(0, 0, 1, 0);
        chk("lap_release", digits, 16'h0013);
        chk("lap_release_held", 16'(lap_held), 16'h0000);
        cycle(0, 0, 0, 0);

        // Pause holds, clear zeroes
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        idle_cycles(28);
        chk("pause_pre_0007", digits, 16'h0007);
        cycle(0, 1, 0, 0);
        idle_cycles(20);
        chk("pause_hold", digits, 16'h0007);
        chk("pause_running", 16'(running), 16'h0000);
        cycle(0, 0, 0, 1);
        chk("clear_digits", digits, 16'h0000);
        chk("clear_ovf", 16'(overflow), 16'h0000);
        cycle(0, 0, 0, 0);

        // Clear and start_stop together in PAUSE; held start_stop toggles once
        cycle(0, 1, 0, 0);
        idle_cycles(13);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 1);
        chk("simul_digits", digits, 16'h0000);
        chk("simul_running", 16'(running), 16'h0000);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 50; i++) cycle(0, 1, 0, 0);
        chk("held_one_toggle", 16'(running), 16'h0001);
        chk("held_count", digits, 16'h0012);
        cycle(0, 0, 0, 0);

        // Reset mid-RUN
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        idle_cycles(168);
        chk("mid_run_0042", digits, 16'h0042);
        cycle(1, 0, 0, 0);
        chk("mid_run_reset_digits", digits, 16'h0000);
        chk("mid_run_reset_running", 16'(running), 16'h0000);
        chk("mid_run_reset_lap", 16'(lap_held), 16'h0000);
        chk("mid_run_reset_ovf", 16'(overflow), 16'h0000);

        // Button held through reset release gives no event
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("held_through_reset", 16'(running), 16'h0000);
        cycle(0, 0, 0, 0);

        // Random button traffic
        ss = 0;
        lp = 0;
        cl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) ss = ~ss;
            if ($urandom_range(6) == 0) lp = ~lp;
            if ($urandom_range(30) == 0) cl = ~cl;
            rs = ($urandom_range(499) == 0);
            cycle(rs, ss, lp, cl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
